// File: rtl/spi_frame_transmitter.sv
// spi_frame_transmitter
//
// Upstream stage of the SPI audio link. Parallel samples arrive through a
// valid/ready handshake and are buffered in a small FIFO. Each sample is then
// serialised MSB-first as one frame:
//   - cs is held low for FRAME_LEN clocks: DATA_W data bits, then zero padding;
//   - cs is then held high for at least GAP_CYCLES clocks.
// When samples are queued back to back, the next frame launches on the last
// gap edge, which gives a frame period of FRAME_LEN + GAP_CYCLES clocks.
//
// Ports:
//   s_clk        serial clock; all state updates on posedge
//   reset        asynchronous, active-low reset
//   in_valid     upstream sample valid
//   in_data      upstream sample (DATA_W bits)
//   in_ready     FIFO can accept a sample (not full)
//   cs           chip-select to the receiver, active-low
//   mosi         serial data to the receiver
//   busy         high whenever the frame FSM is not idle
//   frame_done   one-cycle pulse in the first cs-high clock after a frame
//   fifo_count   current FIFO occupancy
//   frames_sent  count of completed frames, wraps at 16 bits

module spi_frame_transmitter #(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 35,
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        s_clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        cs,
    output logic                        mosi,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 frames_sent
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + GAP_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAD   = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    // Terminal values of the shared per-state cycle counter.
    localparam logic [CW-1:0] SHIFT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] PAD_LAST   = CW'(FRAME_LEN - DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam bit            HAS_PAD    = (FRAME_LEN > DATA_W);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              gap_end;
    logic              frame_end;

    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid && in_ready;
    assign gap_end    = (state == GAP) && (cnt == GAP_LAST);

    // A frame launches from IDLE, or on the last gap edge, whenever a sample
    // is already queued. The launch is the FIFO pop.
    assign pop = !fifo_empty && ((state == IDLE) || gap_end);

    // Without padding, the last SHIFT edge doubles as the frame-end edge.
    assign frame_end = HAS_PAD ? ((state == PAD) && (cnt == PAD_LAST))
                               : ((state == SHIFT) && (cnt == SHIFT_LAST));

    assign busy = (state != IDLE);

    // Occupancy after this edge. A push and a pop in the same cycle cancel.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // FIFO pointers and occupancy. in_ready is registered from the
    // next-state occupancy, so it is exactly !full without a combinational
    // output path.
    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            in_ready   <= (count_next != FULL_COUNT);
        end
    end

    // Sample storage. Contents need no reset because occupancy guards every read.
    always_ff @(posedge s_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Frame FSM. The sample is copied into shreg at launch, so later FIFO
    // writes cannot disturb the frame in flight. mosi is taken from the top
    // of shreg before each shift.
    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            cs          <= 1'b1;
            mosi        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            frame_done <= 1'b0;
            if (pop) begin
                shreg <= mem[rd_ptr];
                mosi  <= mem[rd_ptr][DATA_W-1];
                cs    <= 1'b0;
                cnt   <= '0;
                state <= SHIFT;
            end else if (frame_end) begin
                cs          <= 1'b1;
                mosi        <= 1'b0;
                frame_done  <= 1'b1;
                frames_sent <= frames_sent + 1'b1;
                cnt         <= '0;
                state       <= GAP;
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt == SHIFT_LAST) begin
                            mosi  <= 1'b0;
                            cnt   <= '0;
                            state <= PAD;
                        end else begin
                            mosi  <= shreg[DATA_W-2];
                            shreg <= shreg << 1;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    PAD: begin
                        cnt <= cnt + 1'b1;
                    end
                    GAP: begin
                        // A gap end with a queued sample is handled by the pop branch.
                        if (gap_end) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_transmitter.sv
// tb_spi_frame_transmitter
//
// Self-checking bench for spi_frame_transmitter.
//
// Stimulus:
//   - A vector table supplies sample/expected-word pairs.
//   - Hand-written sequences cover backpressure, a push on a launch edge,
//     frames_sent wrap and a mid-frame reset.
//
// A receiver model samples cs/mosi on the falling edge. It rebuilds every
// frame and compares it with the expected words queued at the handshake. It
// also tracks FIFO occupancy, launch timing, busy, frame_done and
// frames_sent independently of the design.

module tb_spi_frame_transmitter;

    localparam int DATA_W     = 16;
    localparam int FRAME_LEN  = 35;
    localparam int GAP_CYCLES = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_VECS   = 6;

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_word;
        bit          drain_after;
    } vec_t;

    logic             s_clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             cs;
    logic             mosi;
    logic             busy;
    logic             frame_done;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      frames_sent;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_word;
    logic [15:0] sb[$];

    // Receiver / occupancy model state
    int          model_count;
    bit          pend_push;
    logic [15:0] model_fs;
    bit          prev_cs;
    int          high_cnt;
    bit          exp_launch;
    int          low_cnt;
    logic [15:0] rx_bits;
    bit          pad_bad;
    logic [15:0] cur_exp;
    int          fs_seq = 0;
    int          fs_seq_seen = 0;
    int          exp_frames;
    vec_t        vecs [NUM_VECS];

    spi_frame_transmitter #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .GAP_CYCLES(GAP_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .s_clk      (s_clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cs         (cs),
        .mosi       (mosi),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_count (fifo_count),
        .frames_sent(frames_sent)
    );

    always #5 s_clk = ~s_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Hold in_valid until the sample is accepted, then release it just after
    // the accepting edge.
    task automatic applyStimulus(input logic [15:0] d, input logic [15:0] e);
        bit accepted;
        accepted = 0;
        in_valid = 1'b1;
        in_data  = d;
        exp_word = e;
        for (int i = 0; i < 2000 && !accepted; i++) begin
            @(negedge s_clk);
            if (in_ready) accepted = 1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge s_clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge s_clk);
            #1;
            if (!busy && fifo_count == '0 && sb.size() == 0) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
        @(posedge s_clk);
        #1;
    endtask

    task automatic waitFrameDone();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge s_clk);
            if (frame_done) seen = 1;
        end
        if (!seen) checkOutput("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cs"},          32'(cs),          32'd1);
        checkOutput({tag, "_mosi"},        32'(mosi),        32'd0);
        checkOutput({tag, "_in_ready"},    32'(in_ready),    32'd1);
        checkOutput({tag, "_busy"},        32'(busy),        32'd0);
        checkOutput({tag, "_frame_done"},  32'(frame_done),  32'd0);
        checkOutput({tag, "_fifo_count"},  32'(fifo_count),  32'd0);
        checkOutput({tag, "_frames_sent"}, 32'(frames_sent), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        exp_word = '0;
        fork
            // Receiver and scoreboard model, sampled on the falling edge.
            begin
                forever begin
                    @(negedge s_clk);
                    if (!reset) begin
                        sb.delete();
                        model_count = 0;
                        pend_push   = 0;
                        model_fs    = '0;
                        prev_cs     = 1;
                        high_cnt    = GAP_CYCLES + 1;
                        exp_launch  = 0;
                        low_cnt     = 0;
                        pad_bad     = 0;
                        rx_bits     = '0;
                        cur_exp     = '0;
                        fs_seq_seen = fs_seq;
                    end else begin
                        if (fs_seq != fs_seq_seen) begin
                            model_fs    = 16'hFFFF;
                            fs_seq_seen = fs_seq;
                        end
                        if (pend_push) model_count++;
                        if (prev_cs) checkOutput("launch_timing", 32'(!cs), 32'(exp_launch));
                        if (prev_cs && !cs) begin
                            model_count--;
                            checkOutput("frame_expected", 32'(sb.size() != 0), 32'd1);
                            if (sb.size() != 0) cur_exp = sb.pop_front();
                            else cur_exp = '0;
                            low_cnt = 0;
                            pad_bad = 0;
                            rx_bits = '0;
                        end
                        if (!cs) begin
                            if (low_cnt < DATA_W) rx_bits = {rx_bits[14:0], mosi};
                            else if (mosi) pad_bad = 1;
                            low_cnt++;
                        end else begin
                            checkOutput("mosi_idle", 32'(mosi), 32'd0);
                            if (!prev_cs) begin
                                checkOutput("cs_low_len", 32'(low_cnt), 32'(FRAME_LEN));
                                checkOutput("frame_data", 32'(rx_bits), 32'(cur_exp));
                                checkOutput("pad_zero", 32'(pad_bad), 32'd0);
                                model_fs = model_fs + 16'd1;
                                high_cnt = 1;
                            end else if (high_cnt <= GAP_CYCLES) begin
                                high_cnt++;
                            end
                        end
                        checkOutput("frame_done", 32'(frame_done), 32'(cs && !prev_cs));
                        checkOutput("frames_sent", 32'(frames_sent), 32'(model_fs));
                        checkOutput("fifo_count", 32'(fifo_count), 32'(model_count));
                        checkOutput("in_ready", 32'(in_ready), 32'(model_count != FIFO_DEPTH));
                        checkOutput("busy", 32'(busy), 32'(!cs || high_cnt <= GAP_CYCLES));
                        exp_launch = cs && (high_cnt >= GAP_CYCLES) && (model_count != 0);
                        pend_push  = in_valid && (model_count != FIFO_DEPTH);
                        if (pend_push) sb.push_back(exp_word);
                        prev_cs = cs;
                    end
                end
            end

            // Test sequence
            begin
                #2 reset = 1'b0;
                #2;
                checkResetValues("reset");
                repeat (3) @(posedge s_clk);
                #1 reset = 1'b1;

                vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b1};
                vecs[1] = '{16'h0001, 16'h0001, 1'b0};
                vecs[2] = '{16'h8000, 16'h8000, 1'b0};
                vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b0};
                vecs[4] = '{16'h1234, 16'h1234, 1'b1};
                vecs[5] = '{16'h0000, 16'h0000, 1'b1};
                exp_frames = 0;
                for (int i = 0; i < NUM_VECS; i++) begin
                    applyStimulus(vecs[i].data, vecs[i].exp_word);
                    exp_frames++;
                    if (vecs[i].drain_after) begin
                        waitIdle();
                        checkOutput("table_frames_sent", 32'(frames_sent), 32'(exp_frames));
                    end
                end

                // Backpressure: five quick pushes fill the FIFO (one is popped
                // on the launch edge), and the sixth must wait.
                for (int k = 0; k < 5; k++) begin
                    applyStimulus(16'hB000 + 16'(k), 16'hB000 + 16'(k));
                end
                @(negedge s_clk);
                checkOutput("bp_full_count", 32'(fifo_count), 32'd4);
                checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge s_clk);
                #1;
                applyStimulus(16'hB005, 16'hB005);
                waitIdle();
                checkOutput("bp_frames_sent", 32'(frames_sent), 32'd12);

                // Push exactly on the launch edge that ends a gap while two
                // samples are queued.
                applyStimulus(16'hC001, 16'hC001);
                applyStimulus(16'hC002, 16'hC002);
                applyStimulus(16'hC003, 16'hC003);
                waitFrameDone();
                @(posedge s_clk);
                #1;
                applyStimulus(16'hC004, 16'hC004);
                @(negedge s_clk);
                checkOutput("simul_count", 32'(fifo_count), 32'd2);
                checkOutput("simul_cs_low", 32'(cs), 32'd0);
                waitIdle();
                checkOutput("simul_frames_sent", 32'(frames_sent), 32'd16);

                // Preload the frame counter just below wrap.
                @(negedge s_clk);
                #2;
                force dut.frames_sent = 16'hFFFF;
                fs_seq++;
                @(posedge s_clk);
                #1;
                release dut.frames_sent;
                applyStimulus(16'hC0DE, 16'hC0DE);
                waitIdle();
                checkOutput("frames_wrap", 32'(frames_sent), 32'd0);

                // Mid-frame reset while bit 7 is on the wire, with one more
                // sample queued behind it.
                applyStimulus(16'h0F8F, 16'h0F8F);
                applyStimulus(16'h3333, 16'h3333);
                for (int i = 0; i < 100; i++) begin
                    @(negedge s_clk);
                    if (!cs) break;
                end
                repeat (8) @(negedge s_clk);
                checkOutput("bit7_before_reset", 32'(mosi), 32'd1);
                checkOutput("queued_before_reset", 32'(fifo_count), 32'd1);
                #2 reset = 1'b0;
                #1;
                checkResetValues("midreset");
                @(posedge s_clk);
                @(posedge s_clk);
                #1 reset = 1'b1;
                applyStimulus(16'h5A5A, 16'h5A5A);
                waitIdle();
                checkOutput("post_reset_frames_sent", 32'(frames_sent), 32'd1);

                repeat (4) @(posedge s_clk);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join_any
    end

endmodule

// File: doc/spi_frame_transmitter.md
# spi_frame_transmitter

Upstream stage of the SPI audio link: accepts 16-bit parallel samples through a valid/ready handshake, buffers them in a small FIFO, and serialises each one MSB-first onto `cs`/`mosi` in the frame format the SPI receiver expects. The frame format is `cs` low for exactly FRAME_LEN clocks, with 16 data bits followed by zero padding, then `cs` high for at least GAP_CYCLES clocks. The block runs in the `s_clk` domain, and its `cs`/`mosi` outputs wire directly to the receiver's `cs`/`mosi` inputs.

## Interface
- DATA_W, 16: sample width in bits; also the number of data bits per frame.
- FRAME_LEN, 35: number of clocks `cs` is held low per frame; must be ≥ DATA_W.
- GAP_CYCLES, 2: number of clocks `cs` is held high between frames; must be ≥ 1.
- FIFO_DEPTH, 4: number of sample buffer entries; must be a power of 2 and ≥ 2.

- s_clk  input  1  serial clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream sample valid.
- in_data  input  DATA_W  upstream sample.
- in_ready  output  1  FIFO can accept a sample; equals !full.
- cs  output  1  chip-select to the receiver, active-low.
- mosi  output  1  serial data to the receiver.
- busy  output  1  high whenever state ≠ IDLE.
- frame_done  output  1  one-cycle pulse when a frame ends.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frames_sent  output  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- Push condition: a sample is pushed when `in_valid && in_ready` at a posedge.
- Pop condition: a sample is popped when a frame launches (see below).
- Push and pop in the same cycle leave `fifo_count` unchanged.
- When the FIFO is full, `in_ready` is 0 and there is no push, even if a pop happens that cycle.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SHIFT, PAD, GAP.
- IDLE: `cs`=1, `mosi`=0. If FIFO is non-empty, launch a frame:
  - load the FIFO head into the shift register and pop it;
  - drive `cs`<=0 and `mosi`<=data[DATA_W-1];
  - set bit counter to 0 and go to SHIFT.
- SHIFT: each clock, advance `mosi` to the next lower bit. After DATA_W clocks in SHIFT (bit 0 driven in the last one), go to PAD.
- PAD: `cs`=0, `mosi`=0 for FRAME_LEN−DATA_W clocks.
  - On the final PAD edge: drive `cs`<=1, pulse `frame_done`, increment `frames_sent`, go to GAP.
  - If FRAME_LEN==DATA_W, PAD is skipped and these actions happen on the last SHIFT edge.
- GAP: `cs`=1, `mosi`=0 for GAP_CYCLES clocks. At the end:
  - if FIFO is non-empty, launch the next frame on that same edge (as in IDLE);
  - otherwise go to IDLE.
- Frame data is latched at launch, so later FIFO activity never affects the frame in flight.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, FIFO empty, counters 0;
  - `cs`=1, `mosi`=0, `in_ready`=1, `busy`=0, `frame_done`=0, `fifo_count`=0, `frames_sent`=0.
  - The receiver's alignment recovers because `cs` returns high.

## Timing
- All outputs are registered. `cs`/`mosi` change only just after a posedge and are stable for the receiver's next posedge sample.
- Launch latency: a sample pushed into an empty FIFO at edge N in IDLE is popped at edge N+1, where `cs` falls and the MSB appears.
- `fifo_count` reflects the push at edge N, then drops at edge N+1.
- `cs`-low window: exactly FRAME_LEN consecutive clocks per frame.
- Data bits: mosi carries bit DATA_W−1−k during the k-th low clock (k=0..DATA_W−1).
- Frame period for back-to-back samples: FRAME_LEN+GAP_CYCLES clocks; default 37.
- Throughput: one sample per frame period. `in_ready` deasserts only when FIFO_DEPTH samples are queued.
- `frame_done` is high for exactly the one clock in which `cs` first reads 1 after a frame.
- `busy` is high from the launch edge until the GAP→IDLE edge.

## Test plan
- Single sample: push 0xA5C3 after reset → `cs` low 35 clocks; mosi = 1010010111000011 then 19 zeros; one `frame_done`; `frames_sent`=1; a paired receiver shows `data_out`=0xA5C3.
- Back-to-back: push 0x0001, 0x8000, 0xFFFF, 0x1234 in consecutive cycles → 4 frames, each 35 low and 2 high, in order; receiver outputs all four values.
- Backpressure: hold `in_valid` with 6 samples, no frame draining yet → `in_ready`=0 at `fifo_count`=4; no sample lost or duplicated; all 6 transmitted in order.
- Simultaneous push/pop: push exactly on a launch edge with `fifo_count`=2 → count stays 2; order preserved.
- Mid-frame reset: assert reset at SHIFT bit 7 → `cs`=1, `mosi`=0, `fifo_count`=0 immediately; next pushed 0x5A5A is received correctly.
- Counter wrap: force 65536 frames (or preload) → `frames_sent` goes 0xFFFF→0x0000.
